regfile_dump_engine: RTL and testbench

- Hardware reader for the processor register file: walks a range of registers through the two regfile read ports and streams each value out on a valid/ready interface.
- Port A is held at address 0 and used to check that r0 stays 0. Port B addresses the register being dumped.
- Sits beside the processor and regfile in the test skeleton. It replaces software polling of the read ports with a deterministic, handshaked dump.

---
 rtl/regfile_dump_engine_pkg.sv | 26 ++
 rtl/regfile_dump_engine_if.sv | 48 ++++
 rtl/regfile_dump_engine_settle_timer.sv | 42 ++++
 rtl/regfile_dump_engine.sv | 185 ++++++++++++++++++
 tb/tb_regfile_dump_engine.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_dump_engine_pkg.sv
// Shared definitions for the register file dump engine.
//
// Contents:
//   state_e        FSM state encoding (IDLE, ISSUE, SETTLE, PRESENT, FINISH)
//   DEF_NUM_REGS   default architectural register count
//   DEF_ADDR_W     default register address width
//   DEF_DATA_W     default register data width
//   ERR_CNT_MAX    saturation value of the compare mismatch counter
//   SETTLE_W       width of the settle down-counter
package regdump_pkg;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 32;
    localparam int ERR_CNT_MAX  = 255;
    localparam int SETTLE_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SETTLE,
        PRESENT,
        FINISH
    } state_e;

endpackage

// File: rtl/regfile_dump_engine_if.sv
// Bus bundle between the dump engine, the register file read ports and the
// downstream consumer of the dumped values.
//
// Signals:
//   ctrl_readRegA / ctrl_readRegB   read addresses into the register file
//   data_readRegA / data_readRegB   read data returned by the register file
//   out_valid / out_ready           output stream handshake
//   out_index / out_data            register address and value of the beat
//   exp_data                        expected value for out_index (compare build)
//
// Handshake: a beat transfers on every clock edge where out_valid and
// out_ready are both high. Once out_valid rises it stays high, and
// out_index/out_data stay unchanged, until that transfer edge. out_ready may
// change freely and has no effect while out_valid is low.
//
// Modports: master = dump engine, slave = register file + consumer side.
interface regfile_dump_engine_if
    import regdump_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic [ADDR_W-1:0] ctrl_readRegA;
    logic [ADDR_W-1:0] ctrl_readRegB;
    logic [DATA_W-1:0] data_readRegA;
    logic [DATA_W-1:0] data_readRegB;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_index;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] exp_data;

    modport master (
        output ctrl_readRegA, ctrl_readRegB,
        input  data_readRegA, data_readRegB,
        output out_valid, out_index, out_data,
        input  out_ready, exp_data
    );

    modport slave (
        input  ctrl_readRegA, ctrl_readRegB,
        output data_readRegA, data_readRegB,
        input  out_valid, out_index, out_data,
        output out_ready, exp_data
    );

endinterface

// File: rtl/regfile_dump_engine_settle_timer.sv
// Loadable 4-bit down-counter used to wait for register file read data to
// settle after a new address is driven.
//
// Ports:
//   clk_i       clock
//   rst_ni      synchronous active-low reset
//   load_i      load load_val_i into the counter this cycle
//   load_val_i  value to load
//   expired_o   high while the count is zero
module regdump_settle_timer
    import regdump_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic [SETTLE_W-1:0] load_val_i,
    output logic                expired_o
);

    logic [SETTLE_W-1:0] count_q, count_d;

    // Counts down to zero and parks there until reloaded.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - SETTLE_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/regfile_dump_engine.sv
// Register file dump engine: walks a range of registers through read port B,
// presents each value as a valid/ready beat, and watches read port A (held at
// address 0) to flag a nonzero r0.
//
// Optional feature: define REGDUMP_COMPARE_EN to count beats whose out_data
// differs from exp_data (sampled on the accepting cycle) in err_count,
// saturating at 255. Without it err_count is tied to 0 and exp_data is ignored.
//
// Ports:
//   clock       system clock
//   ctrl_reset  synchronous active-low reset
//   start       dump request, honoured only in IDLE
//   start_reg   first register to dump (captured on accepted start)
//   num_regs    number of registers to dump, 0..NUM_REGS (larger saturates)
//   bus         register file read ports + output stream (master side)
//   busy        high in every state except IDLE
//   done        one-cycle pulse the cycle after FINISH
//   zero_err    sticky: r0 read nonzero during the dump
//   err_count   saturating mismatch count (compare build only)
//   dbg_state   current FSM state
module regfile_dump_engine
    import regdump_pkg::*;
#(
    parameter int NUM_REGS      = DEF_NUM_REGS,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     start_reg,
    input  logic [ADDR_W:0]       num_regs,
    regfile_dump_engine_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  zero_err,
    output logic [7:0]            err_count,
    output state_e                dbg_state
);

    localparam logic [ADDR_W:0]     REGS_CNT    = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0]   LAST_REG    = ADDR_W'(NUM_REGS - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic                out_valid_q, out_valid_d;
    logic [ADDR_W-1:0]   out_index_q, out_index_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                done_q, done_d;
    logic                zero_err_q, zero_err_d;
    logic                timer_load;
    logic                timer_expired;
    logic [ADDR_W:0]     req_cnt;
    logic                start_ok;
    logic                beat_accept;

    // Requests larger than the register file are clipped to one full pass.
    assign req_cnt     = (num_regs > REGS_CNT) ? REGS_CNT : num_regs;
    assign start_ok    = (state_q == IDLE) && start;
    assign beat_accept = (state_q == PRESENT) && bus.out_ready;

    regdump_settle_timer u_settle_timer (
        .clk_i      (clock),
        .rst_ni     (ctrl_reset),
        .load_i     (timer_load),
        .load_val_i (SETTLE_LOAD),
        .expired_o  (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        out_data_d  = out_data_q;
        zero_err_d  = zero_err_q;
        timer_load  = 1'b0;
        done_d      = (state_q == FINISH);

        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    cur_d      = start_reg;
                    rem_d      = req_cnt;
                    zero_err_d = 1'b0;
                    state_d    = (req_cnt == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                timer_load = 1'b1;
                state_d    = SETTLE;
            end
            SETTLE: begin
                if (timer_expired) begin
                    out_data_d  = bus.data_readRegB;
                    out_index_d = cur_q;
                    out_valid_d = 1'b1;
                    state_d     = PRESENT;
                    if (bus.data_readRegA != '0) begin
                        zero_err_d = 1'b1;
                    end
                end
            end
            PRESENT: begin
                if (beat_accept) begin
                    out_valid_d = 1'b0;
                    cur_d       = (cur_q == LAST_REG) ? '0 : cur_q + ADDR_W'(1);
                    rem_d       = rem_q - (ADDR_W+1)'(1);
                    state_d     = (rem_q == (ADDR_W+1)'(1)) ? FINISH : ISSUE;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            zero_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            zero_err_q  <= zero_err_d;
        end
    end

`ifdef REGDUMP_COMPARE_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (start_ok) begin
            err_cnt_d = '0;
        end else if (beat_accept && (bus.exp_data != out_data_q) &&
                     (err_cnt_q != 8'(ERR_CNT_MAX))) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    logic unused_exp_data;
    assign unused_exp_data = ^bus.exp_data;
    assign err_count       = '0;
`endif

    assign bus.ctrl_readRegA = '0;
    assign bus.ctrl_readRegB = cur_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_index     = out_index_q;
    assign bus.out_data      = out_data_q;
    assign busy              = (state_q != IDLE);
    assign done              = done_q;
    assign zero_err          = zero_err_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_regfile_dump_engine.sv
// Self-checking bench for regfile_dump_engine: a register file model behind
// the read ports, a table of dump requests, hand-written corner sequences and
// a scoreboard queue of expected {index, data} beats.
module tb_regfile_dump_engine;
    import regdump_pkg::*;

    localparam int NR = 32;
    localparam int AW = 5;
    localparam int DW = 32;

    // ---------------- clock / reset / DUT ----------------
    logic          clock = 1'b0;
    logic          ctrl_reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_reg = '0;
    logic [AW:0]   num_regs = '0;
    logic          busy, done, zero_err;
    logic [7:0]    err_count;
    state_e        dbg_state;

    always #5 clock = ~clock;

    regfile_dump_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    regfile_dump_engine #(
        .NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SETTLE_CYCLES(2)
    ) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .start      (start),
        .start_reg  (start_reg),
        .num_regs   (num_regs),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .zero_err   (zero_err),
        .err_count  (err_count),
        .dbg_state  (dbg_state)
    );

    // ---------------- register file model ----------------
    logic [DW-1:0] regs [NR];
    logic          fault_on = 1'b0;
    logic [AW-1:0] fault_addr = '0;
    logic          mis_on = 1'b0;
    logic [AW-1:0] mis_a = '0, mis_b = '0;

    initial begin
        for (int i = 0; i < NR; i++) regs[i] = DW'(i * 3);
    end

    assign bus.data_readRegB = regs[bus.ctrl_readRegB];
    assign bus.data_readRegA = (fault_on && bus.ctrl_readRegB == fault_addr) ? 32'd5
                                                                            : regs[bus.ctrl_readRegA];
    assign bus.exp_data = regs[bus.out_index] ^
        ((mis_on && (bus.out_index == mis_a || bus.out_index == mis_b)) ? 32'h1 : 32'h0);

`ifdef REGDUMP_COMPARE_EN
    localparam int EXP_ERR = 2;
`else
    localparam int EXP_ERR = 0;
`endif

    // ---------------- scoreboard / counters ----------------
    logic [AW+DW-1:0] exp_q [$];
    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int beat_cnt = 0;
    int done_cnt = 0;
    int run_beat = 0;
    int last_acc = 0;
    bit check_spacing = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Output monitor: beats, done pulses, and stability under backpressure.
    initial begin
        logic          hold_q;
        logic [AW-1:0] hold_idx;
        logic [DW-1:0] hold_data;
        logic [AW+DW-1:0] e;
        hold_q = 1'b0;
        hold_idx = '0;
        hold_data = '0;
        forever begin
            @(negedge clock);
            if (ctrl_reset) begin
                if (done) done_cnt++;
                if (hold_q) begin
                    check("hold_valid", bus.out_valid, 1);
                    check("hold_index", bus.out_index, hold_idx);
                    check("hold_data", bus.out_data, hold_data);
                end
                if (bus.out_valid && bus.out_ready) begin
                    check("beat_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("beat", {bus.out_index, bus.out_data}, e);
                    end
                    check("readRegA_zero", bus.ctrl_readRegA, 0);
                    if (check_spacing && run_beat > 0) check("beat_spacing", cyc - last_acc, 4);
                    last_acc = cyc;
                    beat_cnt++;
                    run_beat++;
                end
                hold_q    = bus.out_valid && !bus.out_ready;
                hold_idx  = bus.out_index;
                hold_data = bus.out_data;
            end else begin
                hold_q = 1'b0;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ready(input int mode);
        case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = (cyc % 3 == 0);
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic push_expected(input int s, input int n);
        int eff;
        eff = (n > NR) ? NR : n;
        for (int i = 0; i < eff; i++) begin
            int idx;
            idx = (s + i) % NR;
            exp_q.push_back({AW'(idx), regs[idx]});
        end
    endtask

    task automatic do_start(input int s, input int n);
        run_beat  = 0;
        start_reg = AW'(s);
        num_regs  = (AW+1)'(n);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int mode, input string name);
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 0;
        for (int k = 0; k < 3000; k++) begin
            if (done_cnt > d0) begin
                seen = 1;
                break;
            end
            set_ready(mode);
            tick();
        end
        check(name, seen, 1);
    endtask

    // ---------------- test vectors ----------------
    typedef struct {
        logic [AW-1:0] s;
        logic [AW:0]   n;
        int            mode;
        int            exp_beats;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int b0, d0;
        bit found;

        vecs[0] = '{5'd0,  6'd32, 0, 32};   // full dump, ready tied high
        vecs[1] = '{5'd30, 6'd4,  1, 4};    // wrap 30,31,0,1 with 1-on/2-off ready
        vecs[2] = '{5'd5,  6'd0,  0, 0};    // empty dump
        vecs[3] = '{5'd10, 6'd40, 2, 32};   // oversize request saturates
        vecs[4] = '{5'd31, 6'd1,  0, 1};    // single last register
        vecs[5] = '{5'd20, 6'd13, 2, 13};   // wrap with random ready

        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_done", done, 0);
        check("rst_zero_err", zero_err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_out_index", bus.out_index, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_readRegB", bus.ctrl_readRegB, 0);
        check("rst_readRegA", bus.ctrl_readRegA, 0);
        ctrl_reset = 1'b1;
        tick();

        // Reset in the middle of a dump, while the 5th beat is presented
        b0 = beat_cnt;
        bus.out_ready = 1'b1;
        push_expected(0, 32);
        do_start(0, 32);
        found = 0;
        for (int k = 0; k < 500; k++) begin
            if (beat_cnt - b0 == 4 && bus.out_valid) begin
                found = 1;
                break;
            end
            tick();
        end
        check("mid_reset_reach_beat5", found, 1);
        bus.out_ready = 1'b0;
        ctrl_reset = 1'b0;
        tick();
        ctrl_reset = 1'b1;
        exp_q.delete();
        d0 = done_cnt;
        check("mid_reset_busy", busy, 0);
        check("mid_reset_valid", bus.out_valid, 0);
        check("mid_reset_readRegB", bus.ctrl_readRegB, 0);
        check("mid_reset_done", done, 0);
        check("mid_reset_state", dbg_state, IDLE);
        repeat (6) tick();
        check("mid_reset_no_done", done_cnt - d0, 0);

        // num_regs = 0: done exactly two cycles after start, no beats
        b0 = beat_cnt;
        do_start(9, 0);
        check("empty_done_c1", done, 0);
        check("empty_busy_c1", busy, 1);
        tick();
        check("empty_done_c2", done, 1);
        check("empty_busy_c2", busy, 0);
        tick();
        check("empty_done_c3", done, 0);
        check("empty_no_beats", beat_cnt - b0, 0);

        // start while busy is ignored
        b0 = beat_cnt;
        push_expected(3, 3);
        do_start(3, 3);
        repeat (2) tick();
        start_reg = 5'd7;
        num_regs  = 6'd5;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        wait_done(0, "busy_start_done");
        repeat (20) tick();
        check("busy_start_beats", beat_cnt - b0, 3);
        check("busy_start_queue", exp_q.size(), 0);
        check("busy_start_idle", busy, 0);

        // r0 fault while the 3rd beat is read
        fault_addr = 5'd2;
        fault_on   = 1'b1;
        push_expected(0, 5);
        do_start(0, 5);
        check("r0_err_clear_at_start", zero_err, 0);
        wait_done(0, "r0_done");
        check("r0_err_set", zero_err, 1);
        fault_on = 1'b0;
        repeat (3) tick();
        check("r0_err_sticky", zero_err, 1);
        push_expected(1, 1);
        do_start(1, 1);
        check("r0_err_cleared", zero_err, 0);
        wait_done(0, "r0_second_done");
        check("r0_err_stays_clear", zero_err, 0);

        // Compare feature: two mismatching beats
        mis_a  = 5'd4;
        mis_b  = 5'd9;
        mis_on = 1'b1;
        push_expected(0, 12);
        do_start(0, 12);
        wait_done(2, "cmp_done");
        check("cmp_err_count", err_count, EXP_ERR);
        mis_on = 1'b0;

        // Table-driven dumps
        for (int v = 0; v < 6; v++) begin
            b0 = beat_cnt;
            d0 = done_cnt;
            check_spacing = (vecs[v].mode == 0);
            push_expected(int'(vecs[v].s), int'(vecs[v].n));
            do_start(int'(vecs[v].s), int'(vecs[v].n));
            check($sformatf("vec%0d_busy", v), busy, 1);
            wait_done(vecs[v].mode, $sformatf("vec%0d_done", v));
            repeat (3) tick();
            check_spacing = 0;
            check($sformatf("vec%0d_beats", v), beat_cnt - b0, vecs[v].exp_beats);
            check($sformatf("vec%0d_done_once", v), done_cnt - d0, 1);
            check($sformatf("vec%0d_queue", v), exp_q.size(), 0);
            check($sformatf("vec%0d_zero_err", v), zero_err, 0);
            check($sformatf("vec%0d_err_count", v), err_count, 0);
            check($sformatf("vec%0d_idle", v), busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
